// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue/writeback stage.
//   W       : datapath width, matches the ALU in1/in2/out_val.
//   NREGS   : register-file depth.
//   REG_AW  : register address width.
//   alu_op_e      : ALU operation encoding.
//   issue_slot_t  : contents of the registered execute slot.
package alu_pkg;

  localparam int W      = 8;
  localparam int NREGS  = 8;
  localparam int REG_AW = $clog2(NREGS);

  typedef enum logic [1:0] {
    ADD   = 2'b00,
    ANDB  = 2'b01,
    XOR   = 2'b10,
    SHIFT = 2'b11
  } alu_op_e;

  typedef struct packed {
    logic [W-1:0]      in1;
    logic [W-1:0]      in2;
    alu_op_e           op;
    logic              sub;
    logic [REG_AW-1:0] rd;
    logic              wr_en;
  } issue_slot_t;

endpackage

// File: rtl/reg_file_8x8.sv
// 8-entry x 8-bit register file.
//   clk, reset          : clock, synchronous active-high reset (clears all entries)
//   ra_addr / ra_data   : combinational read port A
//   rb_addr / rb_data   : combinational read port B
//   dbg_addr / dbg_data : combinational debug read port
//   we, waddr, wdata    : synchronous write port
// r0 always reads zero and writes to it are dropped.
module reg_file_8x8
  import alu_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [REG_AW-1:0] ra_addr,
  output logic [W-1:0]      ra_data,
  input  logic [REG_AW-1:0] rb_addr,
  output logic [W-1:0]      rb_data,
  input  logic [REG_AW-1:0] dbg_addr,
  output logic [W-1:0]      dbg_data,
  input  logic              we,
  input  logic [REG_AW-1:0] waddr,
  input  logic [W-1:0]      wdata
);

  logic [W-1:0] regs [NREGS];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (we && (waddr != '0)) begin
      regs[waddr] <= wdata;
    end
  end

  assign ra_data  = (ra_addr  == '0) ? '0 : regs[ra_addr];
  assign rb_data  = (rb_addr  == '0) ? '0 : regs[rb_addr];
  assign dbg_data = (dbg_addr == '0) ? '0 : regs[dbg_addr];

endmodule

// File: rtl/alu_issue_stage.sv
// Operand-issue and writeback stage in front of the 8-bit combinational ALU.
//   clk, reset              : clock, synchronous active-high reset
//   in_valid / in_ready     : decoded-instruction handshake
//   in_alu_op .. in_imm     : decoded instruction fields
//   stall                   : downstream hold, freezes the execute slot
//   alu_in1/in2/op/sub      : registered execute slot driving the ALU
//   alu_result              : ALU out_val, written back on the fire cycle
//   e_valid                 : execute slot holds a live instruction
//   zero_flag / sign_flag   : flags of the last written-back result
//   dbg_raddr / dbg_rdata   : debug register-file read (r0 reads 0)
//
// Handshake: an instruction transfers on a rising edge where in_valid and
// in_ready are both high. in_ready depends only on slot state (empty, or
// draining this cycle), never on in_valid, so no combinational loop exists.
// The execute slot retires (writes back) on any edge where e_valid is high
// and stall is low.
module alu_issue_stage
  import alu_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        in_alu_op,
  input  logic              in_sub,
  input  logic [REG_AW-1:0] in_rs,
  input  logic [REG_AW-1:0] in_rt,
  input  logic [REG_AW-1:0] in_rd,
  input  logic              in_wr_en,
  input  logic              in_use_imm,
  input  logic [W-1:0]      in_imm,
  input  logic              stall,
  output logic [W-1:0]      alu_in1,
  output logic [W-1:0]      alu_in2,
  output logic [1:0]        alu_op,
  output logic              alu_sub,
  input  logic [W-1:0]      alu_result,
  output logic              e_valid,
  output logic              zero_flag,
  output logic              sign_flag,
  input  logic [REG_AW-1:0] dbg_raddr,
  output logic [W-1:0]      dbg_rdata
);

  issue_slot_t  slot;
  logic         e_valid_q;
  logic         fire_e;
  logic         accept;
  logic [W-1:0] rf_rs, rf_rt;
  logic [W-1:0] fwd_rs, fwd_rt;

  assign fire_e   = e_valid_q & ~stall;
  assign in_ready = ~e_valid_q | ~stall;
  assign accept   = in_valid & in_ready;

  reg_file_8x8 u_rf (
    .clk      (clk),
    .reset    (reset),
    .ra_addr  (in_rs),
    .ra_data  (rf_rs),
    .rb_addr  (in_rt),
    .rb_data  (rf_rt),
    .dbg_addr (dbg_raddr),
    .dbg_data (dbg_rdata),
    .we       (fire_e & slot.wr_en),
    .waddr    (slot.rd),
    .wdata    (alu_result)
  );

  // EX-to-issue bypass: the instruction retiring this cycle has not reached
  // the register file yet, so a dependent reader takes alu_result directly.
  // r0 is excluded so a dropped write to r0 can never leak through.
  always_comb begin
    fwd_rs = rf_rs;
    if (in_rs == '0)
      fwd_rs = '0;
    else if (fire_e && slot.wr_en && (slot.rd == in_rs))
      fwd_rs = alu_result;

    fwd_rt = rf_rt;
    if (in_rt == '0)
      fwd_rt = '0;
    else if (fire_e && slot.wr_en && (slot.rd == in_rt))
      fwd_rt = alu_result;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      slot      <= '0;
      e_valid_q <= 1'b0;
      zero_flag <= 1'b0;
      sign_flag <= 1'b0;
    end else begin
      if (fire_e) begin
        zero_flag <= (alu_result == '0);
        sign_flag <= alu_result[W-1];
      end
      if (accept) begin
        slot.in1   <= fwd_rs;
        slot.in2   <= in_use_imm ? in_imm : fwd_rt;
        slot.op    <= alu_op_e'(in_alu_op);
        slot.sub   <= in_sub;
        slot.rd    <= in_rd;
        slot.wr_en <= in_wr_en;
        e_valid_q  <= 1'b1;
      end else if (fire_e) begin
        // Slot contents are left as-is; only the valid bit drops.
        e_valid_q <= 1'b0;
      end
    end
  end

  assign alu_in1 = slot.in1;
  assign alu_in2 = slot.in2;
  assign alu_op  = slot.op;
  assign alu_sub = slot.sub;
  assign e_valid = e_valid_q;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed testbench for alu_issue_stage with a reference ALU tied to
// alu_result. Inputs change on the falling edge; outputs are checked on the
// falling edge, away from the active rising edge.
module tb_alu_issue_stage;
  import alu_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic              in_valid;
  logic              in_ready;
  logic [1:0]        in_alu_op;
  logic              in_sub;
  logic [REG_AW-1:0] in_rs, in_rt, in_rd;
  logic              in_wr_en, in_use_imm;
  logic [W-1:0]      in_imm;
  logic              stall;
  logic [W-1:0]      alu_in1, alu_in2;
  logic [1:0]        alu_op;
  logic              alu_sub;
  logic [W-1:0]      alu_result;
  logic              e_valid, zero_flag, sign_flag;
  logic [REG_AW-1:0] dbg_raddr;
  logic [W-1:0]      dbg_rdata;

  alu_issue_stage dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_alu_op  (in_alu_op),
    .in_sub     (in_sub),
    .in_rs      (in_rs),
    .in_rt      (in_rt),
    .in_rd      (in_rd),
    .in_wr_en   (in_wr_en),
    .in_use_imm (in_use_imm),
    .in_imm     (in_imm),
    .stall      (stall),
    .alu_in1    (alu_in1),
    .alu_in2    (alu_in2),
    .alu_op     (alu_op),
    .alu_sub    (alu_sub),
    .alu_result (alu_result),
    .e_valid    (e_valid),
    .zero_flag  (zero_flag),
    .sign_flag  (sign_flag),
    .dbg_raddr  (dbg_raddr),
    .dbg_rdata  (dbg_rdata)
  );

  // Reference combinational ALU.
  always_comb begin
    alu_result = '0;
    case (alu_op_e'(alu_op))
      ADD:   alu_result = alu_sub ? (alu_in1 - alu_in2) : (alu_in1 + alu_in2);
      ANDB:  alu_result = alu_in1 & alu_in2;
      XOR:   alu_result = alu_in1 ^ alu_in2;
      SHIFT: alu_result = alu_sub ? (alu_in1 >> alu_in2[2:0]) : (alu_in1 << alu_in2[2:0]);
      default: alu_result = '0;
    endcase
  end

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [W-1:0] exp_q[$];

  task automatic check_val(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input logic [1:0] op, input logic sub, input logic [2:0] rs,
                       input logic [2:0] rt, input logic [2:0] rd, input logic wr,
                       input logic use_imm, input logic [W-1:0] imm);
    in_valid   = 1'b1;
    in_alu_op  = op;
    in_sub     = sub;
    in_rs      = rs;
    in_rt      = rt;
    in_rd      = rd;
    in_wr_en   = wr;
    in_use_imm = use_imm;
    in_imm     = imm;
  endtask

  task automatic idle();
    in_valid = 1'b0;
    in_imm   = W'($urandom_range(0, 255));
  endtask

  task automatic check_reg(input string tag, input logic [2:0] addr, input logic [W-1:0] exp);
    dbg_raddr = addr;
    #1;
    check_val(tag, dbg_rdata, exp);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    idle();
    in_alu_op = 2'b00; in_sub = 1'b0; in_rs = '0; in_rt = '0; in_rd = '0;
    in_wr_en = 1'b0; in_use_imm = 1'b0; stall = 1'b0; dbg_raddr = '0;

    // Reset state
    @(negedge clk);
    step();
    step();
    reset = 1'b0;
    for (int i = 0; i < NREGS; i++) check_reg($sformatf("rst_r%0d", i), 3'(i), 8'h00);
    check_val("rst_e_valid", {7'b0, e_valid}, 8'h00);
    check_val("rst_in_ready", {7'b0, in_ready}, 8'h01);
    check_val("rst_zero", {7'b0, zero_flag}, 8'h00);
    check_val("rst_sign", {7'b0, sign_flag}, 8'h00);

    // Dependent back-to-back adds: r1 = 0 + 5, r2 = r1 + 3
    drive(2'b00, 1'b0, 3'd0, 3'd0, 3'd1, 1'b1, 1'b1, 8'h05);
    step();
    check_val("fwd_a_in1", alu_in1, 8'h00);
    check_val("fwd_a_in2", alu_in2, 8'h05);
    check_val("fwd_a_valid", {7'b0, e_valid}, 8'h01);
    drive(2'b00, 1'b0, 3'd1, 3'd0, 3'd2, 1'b1, 1'b1, 8'h03);
    step();
    check_val("fwd_b_in1", alu_in1, 8'h05);
    check_val("fwd_b_in2", alu_in2, 8'h03);
    idle();
    step();
    check_reg("fwd_r1", 3'd1, 8'h05);
    check_reg("fwd_r2", 3'd2, 8'h08);
    check_val("fwd_sign", {7'b0, sign_flag}, 8'h00);
    check_val("fwd_zero", {7'b0, zero_flag}, 8'h00);
    check_val("fwd_drain_valid", {7'b0, e_valid}, 8'h00);

    // Preload r2 = 7, then sub r3 = r1 - r2 from the register file
    drive(2'b00, 1'b0, 3'd0, 3'd0, 3'd2, 1'b1, 1'b1, 8'h07);
    step();
    idle();
    step();
    step();
    drive(2'b00, 1'b1, 3'd1, 3'd2, 3'd3, 1'b1, 1'b0, 8'hAA);
    step();
    check_val("sub_in1", alu_in1, 8'h05);
    check_val("sub_in2", alu_in2, 8'h07);
    check_val("sub_sub", {7'b0, alu_sub}, 8'h01);
    idle();
    step();
    check_reg("sub_r3", 3'd3, 8'hFE);
    check_val("sub_sign", {7'b0, sign_flag}, 8'h01);
    check_val("sub_zero", {7'b0, zero_flag}, 8'h00);

    // Stall for three cycles with a write of 0x33 to r4 pending
    drive(2'b00, 1'b0, 3'd0, 3'd0, 3'd4, 1'b1, 1'b1, 8'h33);
    stall = 1'b1;
    step();
    idle();
    for (int i = 0; i < 3; i++) begin
      check_val($sformatf("stall%0d_ready", i), {7'b0, in_ready}, 8'h00);
      check_val($sformatf("stall%0d_valid", i), {7'b0, e_valid}, 8'h01);
      check_val($sformatf("stall%0d_in2", i), alu_in2, 8'h33);
      check_reg($sformatf("stall%0d_r4", i), 3'd4, 8'h00);
      check_val($sformatf("stall%0d_sign", i), {7'b0, sign_flag}, 8'h01);
      step();
    end
    stall = 1'b0;
    step();
    check_reg("unstall_r4", 3'd4, 8'h33);
    check_val("unstall_valid", {7'b0, e_valid}, 8'h00);
    check_val("unstall_sign", {7'b0, sign_flag}, 8'h00);

    // Write 0x2A to r0 is dropped and not forwarded
    drive(2'b00, 1'b0, 3'd0, 3'd0, 3'd0, 1'b1, 1'b1, 8'h2A);
    step();
    drive(2'b00, 1'b0, 3'd0, 3'd0, 3'd5, 1'b1, 1'b1, 8'h00);
    step();
    check_val("r0_fwd_in1", alu_in1, 8'h00);
    check_reg("r0_read", 3'd0, 8'h00);
    idle();
    step();
    check_reg("r0_r5", 3'd5, 8'h00);
    check_val("r0_zero", {7'b0, zero_flag}, 8'h01);

    // Full register-file sweep against expected contents
    exp_q = '{8'h00, 8'h05, 8'h07, 8'hFE, 8'h33, 8'h00, 8'h00, 8'h00};
    for (int i = 0; i < NREGS; i++) begin
      logic [W-1:0] e;
      e = exp_q.pop_front();
      check_reg($sformatf("sweep_r%0d", i), 3'(i), e);
    end

    // Reset while the slot holds a stalled write of 0x11 to r4
    drive(2'b00, 1'b0, 3'd0, 3'd0, 3'd4, 1'b1, 1'b1, 8'h11);
    stall = 1'b1;
    step();
    idle();
    check_val("rst2_pre_valid", {7'b0, e_valid}, 8'h01);
    reset = 1'b1;
    step();
    reset = 1'b0;
    stall = 1'b0;
    check_val("rst2_valid", {7'b0, e_valid}, 8'h00);
    check_reg("rst2_r4", 3'd4, 8'h00);
    check_val("rst2_zero", {7'b0, zero_flag}, 8'h00);
    step();
    check_reg("rst2_r4_after", 3'd4, 8'h00);
    check_val("rst2_valid_after", {7'b0, e_valid}, 8'h00);

    // ---------------- final report ----------------
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
